// File: rtl/mac_pkg.sv
// Shared MAC definitions: sequencer state encoding and saturation bounds.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    SETTLE,
    CAPTURE
  } mac_state_e;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sat_mult.sv
// Combinational signed multiply, full-precision product clamped to DATA_WIDTH.
// Zero latency, no flow control.
module sat_mult
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] PMAX = PW'(sat_max(DATA_WIDTH));
  localparam logic signed [PW-1:0] PMIN = PW'(sat_min(DATA_WIDTH));

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  always_comb begin
    a_ext = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
    b_ext = $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    prod  = a_ext * b_ext;
    if (prod > PMAX) begin
      y = PMAX[DATA_WIDTH-1:0];
    end else if (prod < PMIN) begin
      y = PMIN[DATA_WIDTH-1:0];
    end else begin
      y = prod[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mac_product_sequencer.sv
// Feeds N+1 saturated products plus one flush beat into the accumulator, then captures its result.
// acc_data is one cycle after each handshake; in_ready is high only while streaming.
module mac_product_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            number_iterations,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  acc_rstn,
  output logic                  acc_start,
  output logic [DATA_WIDTH-1:0] acc_data,
  input  logic [DATA_WIDTH+2:0] acc_result,
  output logic [DATA_WIDTH+2:0] result_out,
  output logic                  result_valid,
  output logic                  busy
);

  mac_state_e state;
  mac_state_e next;

  logic [7:0]            n_q;
  logic [8:0]            issued;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sat_prod;

  sat_mult #(.DATA_WIDTH(DATA_WIDTH)) u_sat_mult (
    .a (in_a),
    .b (in_b),
    .y (sat_prod)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next     = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    acc_rstn = rstn;
    hs       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next = CLEAR;
      end
      CLEAR: begin
        acc_rstn = 1'b0;
        next     = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        hs       = in_valid;
        // issued still holds the pre-increment count, so N means this beat is the (N+1)th
        if (in_valid && (issued == {1'b0, n_q})) next = FLUSH;
      end
      FLUSH:   next = SETTLE;
      SETTLE:  next = CAPTURE;
      CAPTURE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_q    <= '0;
      issued <= '0;
    end else begin
      if (state == IDLE && start) n_q <= number_iterations;
      if (state == CLEAR) begin
        issued <= '0;
      end else if (hs) begin
        issued <= issued + 9'd1;
      end
    end
  end

  // The flush beat lets the accumulator fold its last pending product
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_start <= 1'b0;
      acc_data  <= '0;
    end else if (hs) begin
      acc_start <= 1'b1;
      acc_data  <= sat_prod;
    end else if (state == FLUSH) begin
      acc_start <= 1'b1;
      acc_data  <= '0;
    end else begin
      acc_start <= 1'b0;
      acc_data  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == CAPTURE);
      if (state == CAPTURE) result_out <= acc_result;
    end
  end

endmodule

// File: tb/tb_mac_product_sequencer.sv
// Bench for mac_product_sequencer with a behavioural accumulator stub and a sum-of-products reference.
module tb_mac_product_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   number_iterations = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         acc_rstn;
  logic         acc_start;
  logic [W-1:0] acc_data;
  logic [W+2:0] acc_result;
  logic [W+2:0] result_out;
  logic         result_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int pa[$];
  int pb[$];

  mac_product_sequencer #(.DATA_WIDTH(W)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start             (start),
    .number_iterations (number_iterations),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .acc_rstn          (acc_rstn),
    .acc_start         (acc_start),
    .acc_data          (acc_data),
    .acc_result        (acc_result),
    .result_out        (result_out),
    .result_valid      (result_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Accumulator stub: input is staged one beat before being added into the sum
  logic signed [W+2:0] acc_sum;
  logic signed [W-1:0] acc_pend;
  always @(posedge clk) begin
    if (!acc_rstn) begin
      acc_sum  <= '0;
      acc_pend <= '0;
    end else if (acc_start) begin
      acc_sum  <= acc_sum + {{3{acc_pend[W-1]}}, acc_pend};
      acc_pend <= acc_data;
    end
  end
  assign acc_result = acc_sum;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int a, input int b);
    int p;
    p = a * b;
    if (p > (1 << (W - 1)) - 1) return (1 << (W - 1)) - 1;
    if (p < -(1 << (W - 1))) return -(1 << (W - 1));
    return p;
  endfunction

  function automatic int wrap_res(input int s);
    logic signed [W+2:0] t;
    t = s[W+2:0];
    return t;
  endfunction

  // mode: 0 no bubbles, 1 alternate bubbles, 2 random bubbles
  task automatic do_run(input int n, input int mode, input bit poke);
    int exp_prod[$];
    int got_prod[$];
    int got_cyc[$];
    int idx, bub, k, vcyc, esum, res;
    bit alt, gap;
    idx = 0; bub = 0; vcyc = -1; esum = 0; res = 0; alt = 1'b0;
    for (int i = 0; i <= n; i++) begin
      exp_prod.push_back(sat(pa[i], pb[i]));
      esum += sat(pa[i], pb[i]);
    end
    exp_prod.push_back(0);

    @(posedge clk); #1;
    start = 1'b1;
    number_iterations = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    number_iterations = 8'($urandom);
    k = 1;
    while (k < 400 && vcyc < 0) begin
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      if (idx <= n) begin
        gap = 1'b0;
        if (in_ready) begin
          if (mode == 1) begin
            gap = alt;
            alt = !alt;
          end else if (mode == 2) begin
            gap = ($urandom_range(0, 2) == 0);
          end
        end
        if (gap) begin
          bub++;
        end else begin
          in_valid = 1'b1;
          in_a = W'(pa[idx]);
          in_b = W'(pb[idx]);
        end
      end
      if (poke && k == 3) begin
        start = 1'b1;
        number_iterations = 8'd200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (acc_start) begin
        got_prod.push_back(int'($signed(acc_data)));
        got_cyc.push_back(k);
      end
      if (in_valid && in_ready) idx++;
      if (result_valid) begin
        vcyc = k;
        res = int'($signed(result_out));
        chk("busy_drop", busy, 0);
      end else if (!busy) begin
        chk("busy_run", busy, 1);
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    start = 1'b0;

    chk("vld_cycle", vcyc, n + 6 + bub);
    chk("result", res, wrap_res(esum));
    chk("n_beats", got_prod.size(), n + 2);
    for (int i = 0; i < exp_prod.size() && i < got_prod.size(); i++) begin
      if (got_prod[i] != exp_prod[i]) chk($sformatf("beat%0d", i), got_prod[i], exp_prod[i]);
    end
    if (got_cyc.size() > 0) chk("flush_cyc", got_cyc[got_cyc.size() - 1], n + 4 + bub);
    if (mode == 0 && got_cyc.size() > 0) chk("first_cyc", got_cyc[0], 3);
    @(negedge clk);
    chk("vld_pulse", result_valid, 0);
    chk("res_hold", int'($signed(result_out)), wrap_res(esum));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_acc_start"}, acc_start, 0);
    chk({tag, "_acc_data"}, acc_data, 0);
    chk({tag, "_res_vld"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_out"}, result_out, 0);
    chk({tag, "_acc_rstn"}, acc_rstn, 0);
  endtask

  initial begin
    int hs_cnt, vcnt, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    pa = {3}; pb = {2};
    do_run(0, 0, 1'b0);

    pa = {1, 2, -2, 3}; pb = {1, 3, 2, -1};
    do_run(3, 0, 1'b1);

    pa = {-8, 7}; pb = {-8, -8};
    do_run(1, 0, 1'b0);

    pa = {1, 2, -2, 3}; pb = {1, 3, 2, -1};
    do_run(3, 1, 1'b0);

    // abort mid-stream after two handshakes
    pa = {3, 3, 3, 3, 3, 3}; pb = {2, 2, 2, 2, 2, 2};
    @(posedge clk); #1;
    start = 1'b1;
    number_iterations = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    hs_cnt = 0;
    for (int c = 0; c < 50 && hs_cnt < 2; c++) begin
      in_valid = 1'b1;
      in_a = W'(pa[hs_cnt]);
      in_b = W'(pb[hs_cnt]);
      @(negedge clk);
      if (in_ready) hs_cnt++;
      @(posedge clk); #1;
    end
    chk("abort_hs", hs_cnt, 2);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    rstn = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (result_valid) vcnt++;
    end
    chk("abort_no_vld", vcnt, 0);
    pa = {3}; pb = {2};
    do_run(0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(0, 12));
      pa.delete();
      pb.delete();
      for (int i = 0; i <= n; i++) begin
        pa.push_back(int'($urandom_range(0, 15)) - 8);
        pb.push_back(int'($urandom_range(0, 15)) - 8);
      end
      do_run(n, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_product_sequencer.md
# mac_product_sequencer

Upstream feeder for the signed accumulator stage. Accepts a stream of signed operand pairs over a valid/ready handshake, multiplies each pair, and saturates the product to DATA_WIDTH. It drives the accumulator's `start_accumulating`/`input_data`/reset pins with exactly `number_iterations+1` products plus the flush cycle the accumulator needs, then captures the accumulator result and pulses `result_valid`. One dot-product per `start`.

## Interface
- DATA_WIDTH, 4, operand, product and `acc_data` width (signed)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; sampled in IDLE only
- number_iterations  in  8  run length minus one; latched on accepted `start`
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when `in_valid && in_ready`
- in_a, in_b  in  DATA_WIDTH  signed operands
- acc_rstn  out  1  synchronous clear to accumulator, active-low
- acc_start  out  1  to accumulator `start_accumulating`
- acc_data  out  DATA_WIDTH  signed saturated product to accumulator `input_data`
- acc_result  in  DATA_WIDTH+3  signed accumulator result
- result_out  out  DATA_WIDTH+3  captured result
- result_valid  out  1  one-cycle pulse, `result_out` valid
- busy  out  1  high in every state except IDLE

## Operation
- FSM states and transitions:
  - IDLE: `start` moves to CLEAR and latches N = `number_iterations`.
  - CLEAR: unconditional move to STREAM.
  - STREAM: moves to FLUSH on the handshake that makes issued count == N+1.
  - FLUSH: unconditional move to SETTLE.
  - SETTLE: unconditional move to CAPTURE.
  - CAPTURE: unconditional move to IDLE.
- `acc_rstn` = 0 while in CLEAR or while `rstn` = 0, else 1. Decoded from the state register.
- `in_ready` = (state == STREAM).
- Issued counter is 9 bits, cleared in CLEAR, incremented per handshake.
- Product is the full 2·DATA_WIDTH signed product `in_a*in_b`, saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `acc_start` and `acc_data` are registered:
  - On a handshake: (1, sat product).
  - In FLUSH: (1, 0). This is the extra cycle the accumulator needs to fold its last product.
  - Otherwise: (0, 0).
- Bubbles (`in_valid` = 0 in STREAM) give `acc_start` = 0. The accumulator holds state, so the result is unaffected.
- CAPTURE: `result_out` <= `acc_result`, `result_valid` <= 1 for one cycle. `result_out` then holds until the next capture.
- Accumulator overflow is not detected; the result is captured as-is.
- `start` outside IDLE is ignored.
- `number_iterations` changes after latch are ignored.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`, `acc_start`, `result_valid`, `busy` = 0
  - `acc_data` = 0
  - `result_out` = 0
  - `acc_rstn` = 0
- `rstn` low mid-run aborts immediately to IDLE. There is no partial result and no `result_valid`.
- Cycle sequence, with `start` sampled at edge 0:
  - Cycle 1 is CLEAR.
  - Handshakes are possible from edge 2.
- With no bubbles:
  - Products appear on `acc_data` in cycles 3..N+3.
  - Flush cycle is N+4.
  - Capture is at edge N+5.
  - `result_valid` is high in cycle N+6.
  - `busy` drops in cycle N+6.
- Each bubble cycle adds one cycle of latency.
- Product latency is 1 cycle from handshake edge to `acc_data`.

## Structure
- Shared package `mac_pkg`:
  - `mac_state_e` enum (IDLE, CLEAR, STREAM, FLUSH, SETTLE, CAPTURE)
  - saturation bounds as functions of DATA_WIDTH
- Sub-module `sat_mult`: combinational signed multiply plus saturate, parameterised by DATA_WIDTH. It is reused by later MAC stages.

## Test plan
- N=0, pair (3,2):
  - `acc_data` = 6 with `acc_start` = 1 in cycle 3.
  - Flush in cycle 4.
  - `result_valid` in cycle 6 with `result_out` = 6.
- N=3, pairs (1,1),(2,3),(−2,2),(3,−1), no bubbles:
  - Products are 1, 6, −4, −3.
  - `result_out` = 0 with `result_valid` in cycle 9.
- Saturation, N=1, pairs (−8,−8),(7,−8):
  - `acc_data` = 7 then −8.
  - `result_out` = −1.
- Bubbles, N=3 pairs as above with `in_valid` low on alternate cycles:
  - `acc_start` is low in gaps.
  - `result_out` = 0.
  - `result_valid` is 3 cycles later than the no-bubble case.
- `start` pulsed during STREAM is ignored. A `number_iterations` change after latch has no effect.
- `rstn` low in STREAM after 2 handshakes:
  - All outputs return to reset values, with no `result_valid`.
  - A following N=0 run with (3,2) returns 6.
